memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory (M) stage of the five-stage pipeline, between Execute_Cycle and the writeback mux/register file. Accepts the EX/MEM bundle (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM), performs word/byte loads and stores over a req/ack data-memory port, and stalls the front of the pipe while an access is outstanding. It registers the MEM/WB bundle and drives ResultW for register-file writeback and forwarding.

## Interface
- DATA_W, 32, datapath/address width
- RD_W, 5, destination register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ValidM  in  1  M-stage slot holds a real instruction (0 = bubble)
- RegWriteM, MemWriteM, ResultSrcM  in  1 each  control from EX/MEM; ResultSrcM 1 = load
- ByteM  in  1  access is byte (LDRB/STRB), else word
- RD_M  in  RD_W  destination register
- PCPlus4M, WriteDataM, ALU_ResultM  in  DATA_W  EX/MEM data; ALU_ResultM is the byte address for memory ops
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  word-aligned address {ALU_ResultM[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with ack
- dmem_ack  in  1  access complete
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- RegWriteW, ResultSrcW  out  1 each  MEM/WB control
- RD_W  out  RD_W  MEM/WB destination
- ALU_ResultW, ReadDataW, PCPlus4W  out  DATA_W  MEM/WB data
- ResultW  out  DATA_W  ResultSrcW ? ReadDataW : ALU_ResultW (combinational from MEM/WB)

## Operation
- Memory op: ValidM && (ResultSrcM || MemWriteM). MemWriteM wins if both set; stores never write a register (RegWriteW=0).
- FSM states IDLE, ACCESS. IDLE + memory op: StallM=1, latch dmem_addr/we/be/wdata, go ACCESS. ACCESS: dmem_req=1; no ack -> stay, StallM=1; ack -> load MEM/WB, StallM=0, go IDLE.
- Non-memory op or bubble in IDLE: MEM/WB loaded next edge; bubble or stall-in-progress writes RegWriteW=0.
- Word access: dmem_be=4'hF, dmem_wdata=WriteDataM; ALU_ResultM[1:0] ignored (aligned down).
- Byte store: dmem_be=1<<ALU_ResultM[1:0], dmem_wdata = WriteDataM[7:0] replicated on four lanes.
- Byte load: ReadDataW = zero-extended lane ALU_ResultM[1:0] of dmem_rdata (lane 0 = bits 7:0). Word load: ReadDataW = dmem_rdata.
- Stores leave ReadDataW at 0.
- Upstream holds all M inputs stable while StallM=1; block samples them only in IDLE.

## Timing
- Reset: state IDLE; dmem_req, dmem_we, StallM, RegWriteW, ResultSrcW = 0; dmem_be=0; all data/address outputs and RD_W = 0.
- Non-memory latency: 1 cycle M -> W.
- Memory op: detect cycle + N ACCESS cycles (N>=1, ack in Nth); W valid the cycle after ack. Zero-wait memory: 2 cycles, 1 stall cycle.
- dmem_* outputs registered; stable throughout ACCESS.
- dmem_ack in IDLE ignored. Ack and StallM never both high.
- rst during ACCESS: IDLE next cycle, dmem_req=0, transaction abandoned; later ack ignored.
- Back-to-back memory ops: second detected in the IDLE cycle after ack; one dead cycle between requests.

## Structure
- Package mem_pkg: mem_state_t {IDLE, ACCESS}; RESULT_ALU=1'b0, RESULT_MEM=1'b1; BE_WORD=4'hF.
- Sub-module dmem_lane_align (combinational): byte-enable generation, store replication, load lane extraction/zero-extend. FSM and MEM/WB register stay in memory_cycle.

## Test plan
- ADD result: ValidM=1, RegWriteM=1, ALU_ResultM=0x2A, RD_M=3 -> next cycle RegWriteW=1, RD_W=3, ResultW=0x2A, StallM never 1.
- Word load, ack 3 cycles after req: ALU_ResultM=0x106 -> dmem_addr=0x104, be=F; StallM high 3 cycles; rdata=0xDEADBEEF -> ResultW=0xDEADBEEF.
- Byte store: ALU_ResultM=0x203, WriteDataM=0x12345678 -> be=4'b1000, wdata=0x78787878, dmem_we=1, RegWriteW=0.
- Byte load lane 2: addr 0x10A, rdata=0xAABBCCDD, zero-wait -> ReadDataW=0x000000BB, exactly 1 stall cycle.
- rst asserted mid-ACCESS, ack two cycles later -> dmem_req=0 after reset edge, no W update, RegWriteW=0.
- Load then store back-to-back, immediate acks -> two distinct requests, one idle cycle between, StallM pattern 1,0,1,0.

Source files
------------

// File: rtl/memory_cycle_pkg.sv
// Shared types and constants for the memory stage: FSM states, result-source
// encodings and byte-enable helpers.
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam logic       RESULT_ALU = 1'b0;
    localparam logic       RESULT_MEM = 1'b1;
    localparam logic [3:0] BE_WORD    = 4'hF;

    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Request/acknowledge data-memory port; the memory stage is the master.
interface memory_cycle_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/memory_cycle_lane_align.sv
// Combinational byte-lane steering: store byte enables/replication and
// zero-extended load lane extraction.
module dmem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              st_byte,
    input  logic [1:0]        st_lane,
    input  logic [DATA_W-1:0] st_data,
    output logic [3:0]        st_be,
    output logic [DATA_W-1:0] st_wdata,
    input  logic              ld_byte,
    input  logic [1:0]        ld_lane,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0] ld_lane_byte;

    always_comb begin
        st_be        = BE_WORD;
        st_wdata     = st_data;
        ld_lane_byte = ld_rdata[{ld_lane, 3'b000} +: 8];
        ld_data      = ld_rdata;
        if (st_byte) begin
            st_be    = byte_be(st_lane);
            st_wdata = {4{st_data[7:0]}};
        end
        if (ld_byte) begin
            ld_data = {{(DATA_W-8){1'b0}}, ld_lane_byte};
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: issues loads/stores over the req/ack port, stalls the front of
// the pipe while an access is outstanding, and holds the MEM/WB register.
module memory_cycle
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RD_IDX_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ValidM,
    input  logic                RegWriteM,
    input  logic                MemWriteM,
    input  logic                ResultSrcM,
    input  logic                ByteM,
    input  logic [RD_IDX_W-1:0] RD_M,
    input  logic [DATA_W-1:0]   PCPlus4M,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [DATA_W-1:0]   ALU_ResultM,
    memory_cycle_if.master      dmem,
    output logic                StallM,
    output logic                RegWriteW,
    output logic                ResultSrcW,
    output logic [RD_IDX_W-1:0] RD_W,
    output logic [DATA_W-1:0]   ALU_ResultW,
    output logic [DATA_W-1:0]   ReadDataW,
    output logic [DATA_W-1:0]   PCPlus4W,
    output logic [DATA_W-1:0]   ResultW
);

    mem_state_t state_q, state_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Instruction held while the access is outstanding
    logic                pend_regwrite_q, pend_regwrite_d;
    logic                pend_store_q, pend_store_d;
    logic                pend_byte_q, pend_byte_d;
    logic [RD_IDX_W-1:0] pend_rd_q, pend_rd_d;
    logic [DATA_W-1:0]   pend_alu_q, pend_alu_d;
    logic [DATA_W-1:0]   pend_pc4_q, pend_pc4_d;

    logic                regwrite_w_q, regwrite_w_d;
    logic                resultsrc_w_q, resultsrc_w_d;
    logic [RD_IDX_W-1:0] rd_w_q, rd_w_d;
    logic [DATA_W-1:0]   alu_w_q, alu_w_d;
    logic [DATA_W-1:0]   rdata_w_q, rdata_w_d;
    logic [DATA_W-1:0]   pc4_w_q, pc4_w_d;

    logic              mem_op;
    logic              stall;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_data;

    assign mem_op = ValidM && (ResultSrcM || MemWriteM);

    dmem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .st_byte  (ByteM),
        .st_lane  (ALU_ResultM[1:0]),
        .st_data  (WriteDataM),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_byte  (pend_byte_q),
        .ld_lane  (pend_alu_q[1:0]),
        .ld_rdata (dmem.rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        pend_regwrite_d = pend_regwrite_q;
        pend_store_d    = pend_store_q;
        pend_byte_d     = pend_byte_q;
        pend_rd_d       = pend_rd_q;
        pend_alu_d      = pend_alu_q;
        pend_pc4_d      = pend_pc4_q;
        regwrite_w_d    = regwrite_w_q;
        resultsrc_w_d   = resultsrc_w_q;
        rd_w_d          = rd_w_q;
        alu_w_d         = alu_w_q;
        rdata_w_d       = rdata_w_q;
        pc4_w_d         = pc4_w_q;
        stall           = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall           = 1'b1;
                    state_d         = ACCESS;
                    req_d           = 1'b1;
                    we_d            = MemWriteM;
                    addr_d          = {ALU_ResultM[DATA_W-1:2], 2'b00};
                    be_d            = st_be;
                    wdata_d         = st_wdata;
                    pend_regwrite_d = RegWriteM;
                    pend_store_d    = MemWriteM;
                    pend_byte_d     = ByteM;
                    pend_rd_d       = RD_M;
                    pend_alu_d      = ALU_ResultM;
                    pend_pc4_d      = PCPlus4M;
                    regwrite_w_d    = 1'b0;
                end else begin
                    regwrite_w_d  = ValidM && RegWriteM;
                    resultsrc_w_d = RESULT_ALU;
                    rd_w_d        = RD_M;
                    alu_w_d       = ALU_ResultM;
                    rdata_w_d     = '0;
                    pc4_w_d       = PCPlus4M;
                end
            end
            ACCESS: begin
                if (dmem.ack) begin
                    state_d       = IDLE;
                    req_d         = 1'b0;
                    regwrite_w_d  = pend_regwrite_q && !pend_store_q;
                    resultsrc_w_d = pend_store_q ? RESULT_ALU : RESULT_MEM;
                    rd_w_d        = pend_rd_q;
                    alu_w_d       = pend_alu_q;
                    rdata_w_d     = pend_store_q ? '0 : ld_data;
                    pc4_w_d       = pend_pc4_q;
                end else begin
                    stall        = 1'b1;
                    regwrite_w_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            be_q            <= '0;
            wdata_q         <= '0;
            pend_regwrite_q <= 1'b0;
            pend_store_q    <= 1'b0;
            pend_byte_q     <= 1'b0;
            pend_rd_q       <= '0;
            pend_alu_q      <= '0;
            pend_pc4_q      <= '0;
            regwrite_w_q    <= 1'b0;
            resultsrc_w_q   <= RESULT_ALU;
            rd_w_q          <= '0;
            alu_w_q         <= '0;
            rdata_w_q       <= '0;
            pc4_w_q         <= '0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            be_q            <= be_d;
            wdata_q         <= wdata_d;
            pend_regwrite_q <= pend_regwrite_d;
            pend_store_q    <= pend_store_d;
            pend_byte_q     <= pend_byte_d;
            pend_rd_q       <= pend_rd_d;
            pend_alu_q      <= pend_alu_d;
            pend_pc4_q      <= pend_pc4_d;
            regwrite_w_q    <= regwrite_w_d;
            resultsrc_w_q   <= resultsrc_w_d;
            rd_w_q          <= rd_w_d;
            alu_w_q         <= alu_w_d;
            rdata_w_q       <= rdata_w_d;
            pc4_w_q         <= pc4_w_d;
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    assign StallM      = stall;
    assign RegWriteW   = regwrite_w_q;
    assign ResultSrcW  = resultsrc_w_q;
    assign RD_W        = rd_w_q;
    assign ALU_ResultW = alu_w_q;
    assign ReadDataW   = rdata_w_q;
    assign PCPlus4W    = pc4_w_q;
    assign ResultW     = resultsrc_w_q ? rdata_w_q : alu_w_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed scenarios plus randomized loads/stores
// against a behavioural model of the stage.
module tb_memory_cycle;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ValidM, RegWriteM, MemWriteM, ResultSrcM, ByteM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        StallM, RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, ResultW;

    memory_cycle_if #(.DATA_W(32)) dmem ();

    memory_cycle #(.DATA_W(32), .RD_IDX_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .ByteM       (ByteM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM),
        .dmem        (dmem),
        .StallM      (StallM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W),
        .ResultW     (ResultW)
    );

    int checks = 0;
    int errors = 0;

    // Observations gathered by issue_mem for the calling scenario to judge
    int          obs_stalls;
    logic [15:0] obs_stall_pat, obs_req_pat;
    logic        obs_stable;
    logic        obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;
    logic        obs_rw, obs_rs;
    logic [4:0]  obs_rd;
    logic [31:0] obs_alu, obs_rdw, obs_pc4, obs_res;

    task automatic bubble();
        ValidM = 1'b0; RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; ByteM = 1'b0;
    endtask

    task automatic issue_mem(input logic st, input logic ld, input logic byt, input logic rw,
                             input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                             input logic [31:0] pc4, input logic [31:0] rdat, input int n);
        ValidM = 1'b1; MemWriteM = st; ResultSrcM = ld; ByteM = byt; RegWriteM = rw;
        RD_M = rd; ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
        obs_stalls = 0; obs_stall_pat = '0; obs_req_pat = '0; obs_stable = 1'b1;
        @(negedge clk);
        obs_stalls += int'(StallM);
        obs_stall_pat = {obs_stall_pat[14:0], StallM};
        obs_req_pat   = {obs_req_pat[14:0], dmem.req};
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            dmem.ack   = (k == n);
            dmem.rdata = (k == n) ? rdat : $urandom;
            @(negedge clk);
            obs_stalls += int'(StallM);
            obs_stall_pat = {obs_stall_pat[14:0], StallM};
            obs_req_pat   = {obs_req_pat[14:0], dmem.req};
            if (!dmem.req) obs_stable = 1'b0;
            if (k == 1) begin
                obs_we = dmem.we; obs_be = dmem.be; obs_addr = dmem.addr; obs_wdata = dmem.wdata;
            end else if (obs_we !== dmem.we || obs_be !== dmem.be ||
                         obs_addr !== dmem.addr || obs_wdata !== dmem.wdata) begin
                obs_stable = 1'b0;
            end
        end
        @(posedge clk); #1;
        dmem.ack = 1'b0;
        obs_rw = RegWriteW; obs_rs = ResultSrcW; obs_rd = RD_W; obs_alu = ALU_ResultW;
        obs_rdw = ReadDataW; obs_pc4 = PCPlus4W; obs_res = ResultW;
        bubble();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bubble();
        RD_M = 5'd17; PCPlus4M = 32'h44; WriteDataM = 32'h55; ALU_ResultM = 32'h66;
        dmem.ack = 1'b0; dmem.rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dmem.req); end
        checks++; if (dmem.we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", dmem.we); end
        checks++; if (dmem.be !== 4'h0) begin errors++; $display("FAIL reset_be got %h want 0", dmem.be); end
        checks++; if (dmem.addr !== 32'h0 || dmem.wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got %h/%h want 0/0", dmem.addr, dmem.wdata); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", StallM); end
        checks++; if (RegWriteW !== 1'b0 || ResultSrcW !== 1'b0) begin errors++; $display("FAIL reset_wctl got %b%b want 00", RegWriteW, ResultSrcW); end
        checks++; if (RD_W !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", RD_W); end
        checks++; if ({ALU_ResultW, ReadDataW, PCPlus4W, ResultW} !== 128'h0) begin errors++; $display("FAIL reset_wdata got %h %h %h %h want 0", ALU_ResultW, ReadDataW, PCPlus4W, ResultW); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic        v, rw;
        logic [4:0]  rd;
        logic [31:0] alu, pc4;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                v = 1'b1; rw = 1'b1; rd = 5'd3; alu = 32'h2A; pc4 = 32'h1004;
            end else begin
                v = 1'($urandom); rw = 1'($urandom); rd = 5'($urandom);
                alu = $urandom; pc4 = $urandom;
            end
            ValidM = v; RegWriteM = rw; MemWriteM = 1'b0; ResultSrcM = 1'b0; ByteM = 1'($urandom);
            RD_M = rd; ALU_ResultM = alu; PCPlus4M = pc4; WriteDataM = $urandom;
            dmem.ack = 1'($urandom);
            @(negedge clk);
            checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL alu_stall[%0d] got %b want 0", i, StallM); end
            @(posedge clk); #1;
            checks++; if (RegWriteW !== (v && rw)) begin errors++; $display("FAIL alu_regwrite[%0d] got %b want %b", i, RegWriteW, v && rw); end
            checks++; if (RD_W !== rd || PCPlus4W !== pc4) begin errors++; $display("FAIL alu_rd_pc4[%0d] got %0d/%h want %0d/%h", i, RD_W, PCPlus4W, rd, pc4); end
            checks++; if (ResultW !== alu || ResultSrcW !== 1'b0) begin errors++; $display("FAIL alu_result[%0d] got %h src %b want %h src 0", i, ResultW, ResultSrcW, alu); end
        end
        dmem.ack = 1'b0;
        bubble();
    endtask

    task automatic test_word_load();
        issue_mem(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h106, 32'h0, 32'h2008, 32'hDEADBEEF, 3);
        checks++; if (obs_addr !== 32'h104 || obs_be !== 4'hF || obs_we !== 1'b0) begin errors++; $display("FAIL wload_req got addr %h be %h we %b want 104 F 0", obs_addr, obs_be, obs_we); end
        checks++; if (obs_stalls != 3) begin errors++; $display("FAIL wload_stalls got %0d want 3", obs_stalls); end
        checks++; if (!obs_stable) begin errors++; $display("FAIL wload_stable got unstable want stable"); end
        checks++; if (obs_res !== 32'hDEADBEEF || obs_rw !== 1'b1 || obs_rd !== 5'd7) begin errors++; $display("FAIL wload_w got %h rw %b rd %0d want DEADBEEF 1 7", obs_res, obs_rw, obs_rd); end
    endtask

    task automatic test_byte_store();
        issue_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h203, 32'h12345678, 32'h3000, 32'hFFFFFFFF, 2);
        checks++; if (obs_be !== 4'b1000 || obs_we !== 1'b1 || obs_addr !== 32'h200) begin errors++; $display("FAIL bstore_req got be %b we %b addr %h want 1000 1 200", obs_be, obs_we, obs_addr); end
        checks++; if (obs_wdata !== 32'h78787878) begin errors++; $display("FAIL bstore_wdata got %h want 78787878", obs_wdata); end
        checks++; if (obs_rw !== 1'b0 || obs_rdw !== 32'h0 || obs_res !== 32'h203) begin errors++; $display("FAIL bstore_w got rw %b rdata %h res %h want 0 0 203", obs_rw, obs_rdw, obs_res); end
    endtask

    task automatic test_byte_load();
        issue_mem(1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h10A, 32'h0, 32'h4000, 32'hAABBCCDD, 1);
        checks++; if (obs_rdw !== 32'h000000BB || obs_res !== 32'h000000BB) begin errors++; $display("FAIL bload_data got %h/%h want 000000BB", obs_rdw, obs_res); end
        checks++; if (obs_stalls != 1) begin errors++; $display("FAIL bload_stalls got %0d want 1", obs_stalls); end
        checks++; if (obs_be !== 4'b0100 || obs_addr !== 32'h108) begin errors++; $display("FAIL bload_req got be %b addr %h want 0100 108", obs_be, obs_addr); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  s1, r1;
        logic [31:0] a1;
        issue_mem(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h500, 32'h0, 32'h10, 32'h11112222, 1);
        s1 = obs_stall_pat[1:0]; r1 = obs_req_pat[1:0]; a1 = obs_addr;
        issue_mem(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h604, 32'h33334444, 32'h14, 32'h0, 1);
        checks++; if ({s1, obs_stall_pat[1:0]} !== 4'b1010) begin errors++; $display("FAIL b2b_stall got %b want 1010", {s1, obs_stall_pat[1:0]}); end
        checks++; if ({r1, obs_req_pat[1:0]} !== 4'b0101) begin errors++; $display("FAIL b2b_req got %b want 0101", {r1, obs_req_pat[1:0]}); end
        checks++; if (a1 !== 32'h500 || obs_addr !== 32'h604 || obs_we !== 1'b1) begin errors++; $display("FAIL b2b_addr got %h %h we %b want 500 604 1", a1, obs_addr, obs_we); end
    endtask

    task automatic test_rst_mid_access();
        ValidM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0; RegWriteM = 1'b1;
        RD_M = 5'd9; ALU_ResultM = 32'h300; PCPlus4M = 32'h50; WriteDataM = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bubble();
        @(negedge clk);
        checks++; if (dmem.req !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL rstacc_req got req %b stall %b want 0 0", dmem.req, StallM); end
        checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL rstacc_rw got %b want 0", RegWriteW); end
        @(posedge clk); #1;
        dmem.ack = 1'b1; dmem.rdata = 32'h55AA55AA;
        @(negedge clk);
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rstacc_stray_ack_stall got %b want 0", StallM); end
        @(posedge clk); #1;
        dmem.ack = 1'b0;
        checks++; if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || dmem.req !== 1'b0) begin errors++; $display("FAIL rstacc_w got rw %b rdata %h req %b want 0 0 0", RegWriteW, ReadDataW, dmem.req); end
    endtask

    task automatic test_random_mem();
        logic st, ld, byt, rw;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4, rdat;
        logic [31:0] e_addr, e_wdata, e_rdw, e_res;
        logic [3:0]  e_be;
        int n, lane;
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom); ld = st ? 1'($urandom) : 1'b1; byt = 1'($urandom); rw = 1'($urandom);
            rd = 5'($urandom); alu = $urandom; wd = $urandom; pc4 = $urandom; rdat = $urandom;
            n = int'($urandom_range(1, 4));
            issue_mem(st, ld, byt, rw, rd, alu, wd, pc4, rdat, n);
            lane    = int'(alu % 4);
            e_addr  = alu - (alu % 4);
            e_be    = byt ? 4'(1 << lane) : 4'hF;
            e_wdata = byt ? (wd % 256) * 32'h01010101 : wd;
            e_rdw   = st ? 32'h0 : (byt ? (rdat / (32'h1 << (8 * lane))) % 256 : rdat);
            e_res   = st ? alu : e_rdw;
            checks++; if (obs_addr !== e_addr || obs_be !== e_be || obs_we !== st) begin errors++; $display("FAIL rnd_req[%0d] got %h %h %b want %h %h %b", i, obs_addr, obs_be, obs_we, e_addr, e_be, st); end
            checks++; if (obs_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, obs_wdata, e_wdata); end
            checks++; if (obs_stalls != n || !obs_stable) begin errors++; $display("FAIL rnd_stall[%0d] got %0d stable %b want %0d 1", i, obs_stalls, obs_stable, n); end
            checks++; if (obs_rw !== (rw && !st) || obs_rs !== !st || obs_rd !== rd) begin errors++; $display("FAIL rnd_wctl[%0d] got %b %b %0d want %b %b %0d", i, obs_rw, obs_rs, obs_rd, rw && !st, !st, rd); end
            checks++; if (obs_rdw !== e_rdw || obs_res !== e_res) begin errors++; $display("FAIL rnd_data[%0d] got %h %h want %h %h", i, obs_rdw, obs_res, e_rdw, e_res); end
            checks++; if (obs_alu !== alu || obs_pc4 !== pc4) begin errors++; $display("FAIL rnd_alu_pc4[%0d] got %h %h want %h %h", i, obs_alu, obs_pc4, alu, pc4); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_back_to_back();
        test_rst_mid_access();
        test_random_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
